// File: rtl/control_unit_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
// Opcode/func constants, ALU op codes, FSM states and the decode bundle.
package control_unit_pkg;

   localparam int ALU_W = 6;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_BLEZ  = 6'h06;
   localparam logic [5:0] OP_BGTZ  = 6'h07;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL     = 6'h00;
   localparam logic [5:0] FN_SRL     = 6'h02;
   localparam logic [5:0] FN_SRA     = 6'h03;
   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_SYSCALL = 6'h0C;
   localparam logic [5:0] FN_MULT    = 6'h18;
   localparam logic [5:0] FN_MULTU   = 6'h19;
   localparam logic [5:0] FN_DIV     = 6'h1A;
   localparam logic [5:0] FN_DIVU    = 6'h1B;
   localparam logic [5:0] FN_ADD     = 6'h20;
   localparam logic [5:0] FN_ADDU    = 6'h21;
   localparam logic [5:0] FN_SUB     = 6'h22;
   localparam logic [5:0] FN_SUBU    = 6'h23;
   localparam logic [5:0] FN_AND     = 6'h24;
   localparam logic [5:0] FN_OR      = 6'h25;
   localparam logic [5:0] FN_XOR     = 6'h26;
   localparam logic [5:0] FN_NOR     = 6'h27;
   localparam logic [5:0] FN_SLT     = 6'h2A;
   localparam logic [5:0] FN_SLTU    = 6'h2B;

   localparam logic [ALU_W-1:0] ALU_ADD   = 6'd0;
   localparam logic [ALU_W-1:0] ALU_SUB   = 6'd1;
   localparam logic [ALU_W-1:0] ALU_AND   = 6'd2;
   localparam logic [ALU_W-1:0] ALU_OR    = 6'd3;
   localparam logic [ALU_W-1:0] ALU_XOR   = 6'd4;
   localparam logic [ALU_W-1:0] ALU_NOR   = 6'd5;
   localparam logic [ALU_W-1:0] ALU_SLT   = 6'd6;
   localparam logic [ALU_W-1:0] ALU_SLTU  = 6'd7;
   localparam logic [ALU_W-1:0] ALU_SLL   = 6'd8;
   localparam logic [ALU_W-1:0] ALU_SRL   = 6'd9;
   localparam logic [ALU_W-1:0] ALU_SRA   = 6'd10;
   localparam logic [ALU_W-1:0] ALU_LUI   = 6'd11;
   localparam logic [ALU_W-1:0] ALU_MULT  = 6'd12;
   localparam logic [ALU_W-1:0] ALU_MULTU = 6'd13;
   localparam logic [ALU_W-1:0] ALU_DIV   = 6'd14;
   localparam logic [ALU_W-1:0] ALU_DIVU  = 6'd15;

   typedef enum logic [2:0] {
      FETCH, DECODE, EXEC, MEM, MULDIV, WB, HALT, TRAP
   } state_t;

   typedef enum logic [3:0] {
      CLS_RALU, CLS_IALU, CLS_LOAD, CLS_STORE,
      CLS_MULDIV, CLS_BRANCH, CLS_JUMP, CLS_JR,
      CLS_JAL, CLS_SYSCALL, CLS_ILLEGAL
   } instr_class_t;

   typedef struct packed {
      logic             reg_dest;
      logic             link;
      logic             jump;
      logic             jump_reg;
      logic             branch;
      logic             mem_to_reg;
      logic             alu_src;
      logic [ALU_W-1:0] alu_op;
   } ctrl_bundle_t;

   // Sequencing class of an instruction word; anything unlisted traps.
   function automatic instr_class_t classify(
      input logic [5:0] op,
      input logic [5:0] fn
   );
      instr_class_t c;
      c = CLS_ILLEGAL;
      unique case (op)
         OP_RTYPE: begin
            unique case (fn)
               FN_SLL, FN_SRL, FN_SRA,
               FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
               FN_AND, FN_OR, FN_XOR, FN_NOR,
               FN_SLT, FN_SLTU:  c = CLS_RALU;
               FN_JR:            c = CLS_JR;
               FN_SYSCALL:       c = CLS_SYSCALL;
               FN_MULT, FN_MULTU,
               FN_DIV, FN_DIVU:  c = CLS_MULDIV;
               default:          c = CLS_ILLEGAL;
            endcase
         end
         OP_J:    c = CLS_JUMP;
         OP_JAL:  c = CLS_JAL;
         OP_BEQ, OP_BNE,
         OP_BLEZ, OP_BGTZ: c = CLS_BRANCH;
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                  c = CLS_IALU;
         OP_LW:   c = CLS_LOAD;
         OP_SW:   c = CLS_STORE;
         default: c = CLS_ILLEGAL;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational decode of the latched opcode/func into a class and
// the datapath mux bundle; the FSM decides when each field is live.
module cu_decoder
   import control_unit_pkg::*;
(
   input  logic [5:0]   opcode,
   input  logic [5:0]   func,
   output instr_class_t cls,
   output ctrl_bundle_t ctrl
);

   // Class, mux selects and ALU operation for the held instruction.
   always_comb begin
      cls             = classify(opcode, func);
      ctrl            = '0;
      ctrl.reg_dest   = (cls == CLS_RALU);
      ctrl.link       = (cls == CLS_JAL);
      ctrl.jump       = (cls inside {CLS_JUMP, CLS_JR, CLS_JAL});
      ctrl.jump_reg   = (cls == CLS_JR);
      ctrl.branch     = (cls == CLS_BRANCH);
      ctrl.mem_to_reg = (cls == CLS_LOAD);
      ctrl.alu_src    = (cls inside {CLS_IALU, CLS_LOAD, CLS_STORE});
      ctrl.alu_op     = ALU_ADD;
      unique case (opcode)
         OP_RTYPE: begin
            unique case (func)
               FN_SUB, FN_SUBU: ctrl.alu_op = ALU_SUB;
               FN_AND:          ctrl.alu_op = ALU_AND;
               FN_OR:           ctrl.alu_op = ALU_OR;
               FN_XOR:          ctrl.alu_op = ALU_XOR;
               FN_NOR:          ctrl.alu_op = ALU_NOR;
               FN_SLT:          ctrl.alu_op = ALU_SLT;
               FN_SLTU:         ctrl.alu_op = ALU_SLTU;
               FN_SLL:          ctrl.alu_op = ALU_SLL;
               FN_SRL:          ctrl.alu_op = ALU_SRL;
               FN_SRA:          ctrl.alu_op = ALU_SRA;
               FN_MULT:         ctrl.alu_op = ALU_MULT;
               FN_MULTU:        ctrl.alu_op = ALU_MULTU;
               FN_DIV:          ctrl.alu_op = ALU_DIV;
               FN_DIVU:         ctrl.alu_op = ALU_DIVU;
               default:         ctrl.alu_op = ALU_ADD;
            endcase
         end
         OP_BEQ, OP_BNE,
         OP_BLEZ, OP_BGTZ: ctrl.alu_op = ALU_SUB;
         OP_SLTI:  ctrl.alu_op = ALU_SLT;
         OP_SLTIU: ctrl.alu_op = ALU_SLTU;
         OP_ANDI:  ctrl.alu_op = ALU_AND;
         OP_ORI:   ctrl.alu_op = ALU_OR;
         OP_XORI:  ctrl.alu_op = ALU_XOR;
         OP_LUI:   ctrl.alu_op = ALU_LUI;
         default:  ctrl.alu_op = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/MULDIV/WB with
// memory-ready stalls, a MULT/DIV wait counter and sticky halt/trap.
module multicycle_control_unit
   import control_unit_pkg::*;
#(
   parameter int ALUOP_W       = 6,
   parameter int MULDIV_CYCLES = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         opcode,
   input  logic [5:0]         func,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               ir_write,
   output logic               inst_read,
   output logic               reg_dest,
   output logic               link,
   output logic               jump,
   output logic               jump_reg,
   output logic               branch,
   output logic               mem_to_reg,
   output logic               alu_src,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               mem_read,
   output logic               mem_write,
   output logic               reg_write,
   output logic               muldiv_start,
   output logic               halted,
   output logic               illegal_instr
);

   localparam logic [7:0] CNT_LAST = 8'(MULDIV_CYCLES);

   state_t       state_q, state_d;
   logic [5:0]   op_q, op_d;
   logic [5:0]   fn_q, fn_d;
   logic [7:0]   cnt_q, cnt_d;
   logic         halted_q, halted_d;
   logic         illegal_q, illegal_d;
   instr_class_t cls;
   instr_class_t live_cls;
   ctrl_bundle_t ctrl;

   cu_decoder u_dec (
      .opcode (op_q),
      .func   (fn_q),
      .cls    (cls),
      .ctrl   (ctrl)
   );

   // Only the HALT/TRAP exit from DECODE needs the incoming word.
   assign live_cls = classify(opcode, func);

   // Next state, instruction latch, MULT/DIV counter and sticky flags.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      fn_d      = fn_q;
      cnt_d     = cnt_q;
      halted_d  = halted_q;
      illegal_d = illegal_q;
      unique case (state_q)
         FETCH: begin
            if (mem_ready) state_d = DECODE;
         end
         DECODE: begin
            op_d = opcode;
            fn_d = func;
            unique case (live_cls)
               CLS_SYSCALL: begin
                  state_d  = HALT;
                  halted_d = 1'b1;
               end
               CLS_ILLEGAL: begin
                  state_d   = TRAP;
                  illegal_d = 1'b1;
               end
               default: state_d = EXEC;
            endcase
         end
         EXEC: begin
            unique case (cls)
               CLS_RALU, CLS_IALU:  state_d = WB;
               CLS_LOAD, CLS_STORE: state_d = MEM;
               CLS_MULDIV: begin
                  state_d = MULDIV;
                  cnt_d   = 8'd1;
               end
               default: state_d = FETCH;
            endcase
         end
         MEM: begin
            if (mem_ready)
               state_d = (cls == CLS_LOAD) ? WB : FETCH;
         end
         MULDIV: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = WB;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         WB:      state_d = FETCH;
         default: state_d = state_q;
      endcase
   end

   // State registers; reset aborts any instruction in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FETCH;
         op_q      <= '0;
         fn_q      <= '0;
         cnt_q     <= '0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         fn_q      <= fn_d;
         cnt_q     <= cnt_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
      end
   end

   // Strobes per state; held low while rst so nothing half-completes.
   always_comb begin
      pc_write     = 1'b0;
      ir_write     = 1'b0;
      inst_read    = 1'b0;
      reg_dest     = 1'b0;
      link         = 1'b0;
      jump         = 1'b0;
      jump_reg     = 1'b0;
      branch       = 1'b0;
      mem_to_reg   = 1'b0;
      alu_src      = 1'b0;
      alu_op       = ALUOP_W'(ALU_ADD);
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      reg_write    = 1'b0;
      muldiv_start = 1'b0;
      if (!rst) begin
         unique case (state_q)
            FETCH: begin
               inst_read = 1'b1;
               ir_write  = mem_ready;
            end
            EXEC: begin
               alu_op       = ALUOP_W'(ctrl.alu_op);
               alu_src      = ctrl.alu_src;
               reg_dest     = ctrl.reg_dest;
               jump         = ctrl.jump;
               jump_reg     = ctrl.jump_reg;
               link         = ctrl.link;
               branch       = ctrl.branch;
               pc_write     = ctrl.jump | ctrl.branch;
               reg_write    = ctrl.link;
               muldiv_start = (cls == CLS_MULDIV);
            end
            MEM: begin
               alu_op    = ALUOP_W'(ctrl.alu_op);
               alu_src   = ctrl.alu_src;
               mem_read  = (cls == CLS_LOAD);
               mem_write = (cls == CLS_STORE);
               pc_write  = (cls == CLS_STORE) & mem_ready;
            end
            MULDIV: begin
               alu_op = ALUOP_W'(ctrl.alu_op);
            end
            WB: begin
               alu_op     = ALUOP_W'(ctrl.alu_op);
               alu_src    = ctrl.alu_src;
               reg_dest   = ctrl.reg_dest;
               mem_to_reg = ctrl.mem_to_reg;
               reg_write  = 1'b1;
               pc_write   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign halted        = halted_q;
   assign illegal_instr = illegal_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-instruction timeline model
// with random memory waits, random noise and directed corner cases.
module tb_multicycle_control_unit;
   import control_unit_pkg::*;

   localparam int N = 4;

   localparam int K_ALU = 0;
   localparam int K_LW  = 1;
   localparam int K_SW  = 2;
   localparam int K_MD  = 3;
   localparam int K_BR  = 4;
   localparam int K_J   = 5;
   localparam int K_JR  = 6;
   localparam int K_JAL = 7;
   localparam int K_SYS = 8;
   localparam int K_ILL = 9;

   logic       clk;
   logic       rst;
   logic [5:0] opcode;
   logic [5:0] func;
   logic       mem_ready;
   logic       pc_write, ir_write, inst_read;
   logic       reg_dest, link, jump, jump_reg;
   logic       branch, mem_to_reg, alu_src;
   logic [5:0] alu_op;
   logic       mem_read, mem_write, reg_write;
   logic       muldiv_start, halted, illegal_instr;

   int n_vec = 0;
   int n_err = 0;
   bit h_m   = 0;
   bit i_m   = 0;

   logic [11:0] tbl [16] = '{
      {6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h24},
      {6'h00, 6'h2A}, {6'h00, 6'h00}, {6'h0D, 6'h00},
      {6'h08, 6'h00}, {6'h23, 6'h00}, {6'h2B, 6'h00},
      {6'h04, 6'h00}, {6'h05, 6'h00}, {6'h02, 6'h00},
      {6'h00, 6'h08}, {6'h03, 6'h00}, {6'h00, 6'h19},
      {6'h0F, 6'h00}
   };

   multicycle_control_unit #(
      .ALUOP_W       (6),
      .MULDIV_CYCLES (N)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .opcode        (opcode),
      .func          (func),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .ir_write      (ir_write),
      .inst_read     (inst_read),
      .reg_dest      (reg_dest),
      .link          (link),
      .jump          (jump),
      .jump_reg      (jump_reg),
      .branch        (branch),
      .mem_to_reg    (mem_to_reg),
      .alu_src       (alu_src),
      .alu_op        (alu_op),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .reg_write     (reg_write),
      .muldiv_start  (muldiv_start),
      .halted        (halted),
      .illegal_instr (illegal_instr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction kind straight from the MIPS opcode/func map.
   function automatic int kind_of(logic [5:0] op, logic [5:0] fn);
      if (op == 6'h00) begin
         if (fn == 6'h08) return K_JR;
         if (fn == 6'h0C) return K_SYS;
         if (fn inside {[6'h18:6'h1B]}) return K_MD;
         if (fn inside {6'h00, 6'h02, 6'h03, [6'h20:6'h27],
                        6'h2A, 6'h2B}) return K_ALU;
         return K_ILL;
      end
      if (op == 6'h02) return K_J;
      if (op == 6'h03) return K_JAL;
      if (op inside {[6'h04:6'h07]}) return K_BR;
      if (op inside {[6'h08:6'h0F]}) return K_ALU;
      if (op == 6'h23) return K_LW;
      if (op == 6'h2B) return K_SW;
      return K_ILL;
   endfunction

   // Expected ALU op for a few well-known instructions, else -1.
   function automatic int exp_alu(logic [5:0] op, logic [5:0] fn);
      if (op == 6'h00) begin
         if (fn inside {6'h20, 6'h21}) return int'(ALU_ADD);
         if (fn inside {6'h22, 6'h23}) return int'(ALU_SUB);
         if (fn == 6'h24) return int'(ALU_AND);
         if (fn == 6'h25) return int'(ALU_OR);
         if (fn == 6'h2A) return int'(ALU_SLT);
         return -1;
      end
      if (op inside {6'h08, 6'h09, 6'h23, 6'h2B})
         return int'(ALU_ADD);
      if (op == 6'h0D) return int'(ALU_OR);
      return -1;
   endfunction

   task automatic chk(string tag, int k,
                      logic [31:0] act, logic [31:0] exp);
      n_vec++;
      assert (act === exp) else begin
         n_err++;
         $error("FAIL %s cyc %0d: got %0h exp %0h",
                tag, k, act, exp);
      end
   endtask

   // One instruction from FETCH entry; rst_at<0 means no abort.
   task automatic run(logic [5:0] op, logic [5:0] fn,
                      int fw, int mw, int rst_at);
      int kd, f, d, e, ms, last, ra, ea;
      bit absorb, mwin, rw;
      logic [13:0] act, exv;
      kd     = kind_of(op, fn);
      f      = fw;
      d      = fw + 1;
      e      = fw + 2;
      ms     = fw + 3;
      ra     = rst_at;
      absorb = (kd == K_SYS) || (kd == K_ILL);
      mwin   = (kd == K_LW) || (kd == K_SW);
      rw     = kd inside {K_ALU, K_LW, K_MD, K_JAL};
      if (kd == K_ALU)     last = f + 3;
      else if (kd == K_LW) last = f + 4 + mw;
      else if (kd == K_SW) last = f + 3 + mw;
      else if (kd == K_MD) last = f + 3 + N;
      else if (absorb)     last = d + 20;
      else                 last = e;
      if (absorb) ra = last;
      for (int k = 0; k <= last; k++) begin
         @(negedge clk);
         rst = (k == ra);
         if (k <= f)
            mem_ready = (k == f);
         else if (mwin && k >= ms && k <= ms + mw)
            mem_ready = (k == ms + mw);
         else
            mem_ready = 1'($urandom_range(0, 1));
         if (k <= d) begin
            opcode = op;
            func   = fn;
         end else begin
            opcode = 6'($urandom);
            func   = 6'($urandom);
         end
         if (k == d + 1 && kd == K_SYS) h_m = 1'b1;
         if (k == d + 1 && kd == K_ILL) i_m = 1'b1;
         #1;
         act = {inst_read, ir_write, pc_write, reg_write,
                mem_read, mem_write, muldiv_start, mem_to_reg,
                jump, link, branch, jump_reg,
                halted, illegal_instr};
         exv = '0;
         if (k != ra) begin
            exv[13] = (k <= f);
            exv[12] = (k == f);
            exv[11] = !absorb && (k == last);
            exv[10] = rw && (k == last);
            exv[9]  = (kd == K_LW) && k >= ms && k <= ms + mw;
            exv[8]  = (kd == K_SW) && k >= ms && k <= ms + mw;
            exv[7]  = (kd == K_MD) && (k == e);
            exv[6]  = (kd == K_LW) && (k == last);
            exv[5]  = (k == e) && (kd inside {K_J, K_JR, K_JAL});
            exv[4]  = (k == e) && (kd == K_JAL);
            exv[3]  = (k == e) && (kd == K_BR);
            exv[2]  = (k == e) && (kd == K_JR);
         end
         exv[1] = h_m;
         exv[0] = i_m;
         chk("strobes", k, 32'(act), 32'(exv));
         if (k == e && !absorb && k != ra) begin
            chk("alu_src", k, 32'(alu_src),
                32'(kd inside {K_LW, K_SW} ||
                    (kd == K_ALU && op != 6'h00)));
            chk("reg_dest", k, 32'(reg_dest),
                32'(kd == K_ALU && op == 6'h00));
            ea = exp_alu(op, fn);
            if (ea >= 0)
               chk("alu_op", k, 32'(alu_op), 32'(ea));
         end
         if (k == ra) begin
            h_m = 1'b0;
            i_m = 1'b0;
            break;
         end
      end
   endtask

   initial begin
      logic [11:0] ent;
      logic [5:0]  rfn;
      rst       = 1'b1;
      opcode    = '0;
      func      = '0;
      mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_strobes", 0,
          32'({inst_read, ir_write, pc_write, reg_write,
               mem_read, mem_write, muldiv_start, jump,
               link, branch, halted, illegal_instr}), 32'd0);
      chk("reset_alu_op", 0, 32'(alu_op), 32'(ALU_ADD));

      run(6'h00, 6'h20, 0, 0, -1);
      run(6'h23, 6'h00, 0, 3, -1);
      run(6'h00, 6'h18, 0, 0, -1);
      run(6'h03, 6'h00, 0, 0, -1);
      run(6'h3F, 6'h00, 0, 0, -1);
      run(6'h00, 6'h20, 1, 0, -1);
      run(6'h00, 6'h0C, 1, 0, -1);
      run(6'h00, 6'h3F, 0, 0, -1);
      run(6'h2B, 6'h00, 0, 3, 5);
      run(6'h00, 6'h1A, 0, 0, 5);
      run(6'h2B, 6'h00, 2, 1, -1);
      run(6'h00, 6'h08, 0, 0, -1);

      for (int i = 0; i < 40; i++) begin
         ent = tbl[$urandom_range(0, 15)];
         rfn = (ent[11:6] == 6'h00) ? ent[5:0] : 6'($urandom);
         run(ent[11:6], rfn, $urandom_range(0, 2),
             $urandom_range(0, 2), -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
